// File: rtl/pc_fetch_unit_if.sv
// Purpose: bundles the fetch unit's control inputs and its PC/Done outputs.
// Signals:
//   Start, JumpEqual, JumpNotEqual, OffsetEn, PCRegSelect[1:0], Ack, ZeroFlag,
//   OffsetData[OFF_WIDTH-1:0]       -> into the fetch unit
//   ProgCtr[PC_WIDTH-1:0], Done     <- from the fetch unit
// Modports: master (drives the controls, observes the PC), slave (the fetch unit).
interface pc_fetch_unit_if #(
  parameter int unsigned PC_WIDTH  = 10,
  parameter int unsigned OFF_WIDTH = 8
);
  logic                 Start;
  logic                 JumpEqual;
  logic                 JumpNotEqual;
  logic                 OffsetEn;
  logic [1:0]           PCRegSelect;
  logic                 Ack;
  logic                 ZeroFlag;
  logic [OFF_WIDTH-1:0] OffsetData;
  logic [PC_WIDTH-1:0]  ProgCtr;
  logic                 Done;

  modport master (
    output Start, JumpEqual, JumpNotEqual, OffsetEn, PCRegSelect, Ack, ZeroFlag, OffsetData,
    input  ProgCtr, Done
  );

  modport slave (
    input  Start, JumpEqual, JumpNotEqual, OffsetEn, PCRegSelect, Ack, ZeroFlag, OffsetData,
    output ProgCtr, Done
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Purpose: program counter / fetch sequencer. Steps ProgCtr one instruction per
// cycle, saves return addresses into PCreg1..3 (spc) and branches through them
// (je/jne), and sequences program start (Start) and completion (Done).
// Ports:
//   Clk    rising-edge clock
//   Reset  asynchronous, active-high reset
//   bus    pc_fetch_unit_if.slave: decoder controls in, ProgCtr/Done out
module pc_fetch_unit #(
  parameter int unsigned PC_WIDTH  = 10,
  parameter int unsigned OFF_WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  pc_fetch_unit_if.slave   bus
);

  localparam int unsigned NUM_REGS = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]          state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic                done, done_nxt;
  logic [PC_WIDTH-1:0] pcreg     [NUM_REGS];
  logic [PC_WIDTH-1:0] pcreg_nxt [NUM_REGS];

  logic [PC_WIDTH-1:0] pc_inc_c;
  logic [PC_WIDTH-1:0] off_sum_c;
  logic [1:0]          sel_idx_c;
  logic                sel_any_c;
  logic                strobe_c;
  logic                taken_c;

  // Datapath helpers; all sums wrap modulo 2**PC_WIDTH by truncation.
  assign pc_inc_c  = pc + PC_WIDTH'(1);
  assign off_sum_c = pc + PC_WIDTH'(bus.OffsetData);
  assign sel_idx_c = bus.PCRegSelect - 2'd1;
  assign sel_any_c = (bus.PCRegSelect != 2'd0);
  assign strobe_c  = bus.JumpEqual | bus.JumpNotEqual;
  // Both strobes together is illegal but resolves to taken regardless of the flag.
  assign taken_c   = (bus.JumpEqual & bus.ZeroFlag) | (bus.JumpNotEqual & ~bus.ZeroFlag);

  // State and datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      pc    <= '0;
      done  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) pcreg[i] <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      done  <= done_nxt;
      for (int i = 0; i < NUM_REGS; i++) pcreg[i] <= pcreg_nxt[i];
    end
  end

  // Next-state and datapath selection.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    done_nxt  = done;
    for (int i = 0; i < NUM_REGS; i++) pcreg_nxt[i] = pcreg[i];

    case (state)
      S_IDLE: begin
        pc_nxt = '0;
        if (bus.Start) begin
          state_nxt = S_ARM;
          done_nxt  = 1'b0;
        end
      end
      S_ARM: begin
        pc_nxt   = '0;
        done_nxt = 1'b0;
        if (!bus.Start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.Start) begin
          // Restart request overrides everything, including the halt word.
          state_nxt = S_ARM;
          pc_nxt    = '0;
          done_nxt  = 1'b0;
        end else if (bus.Ack) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else if (strobe_c) begin
          pc_nxt = (taken_c && sel_any_c) ? pcreg[sel_idx_c] : pc_inc_c;
        end else begin
          if (sel_any_c) pcreg_nxt[sel_idx_c] = bus.OffsetEn ? off_sum_c : pc_inc_c;
          pc_nxt = pc_inc_c;
        end
      end
      S_DONE: begin
        if (bus.Start) begin
          state_nxt = S_ARM;
          pc_nxt    = '0;
          done_nxt  = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.ProgCtr = pc;
  assign bus.Done    = done;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Purpose: self-checking bench for pc_fetch_unit against a behavioural model.
module tb_pc_fetch_unit;

  localparam int unsigned PW = 10;
  localparam int unsigned OW = 8;
  localparam int PC_MOD = 1024;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  typedef logic [PW-1:0] pc_t;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  pc_fetch_unit_if #(.PC_WIDTH(PW), .OFF_WIDTH(OW)) bus ();

  pc_fetch_unit #(.PC_WIDTH(PW), .OFF_WIDTH(OW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: program phase, PC, saved addresses, done flag.
  int m_mode;
  int m_pc;
  int m_reg [4];
  bit m_done;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pc   = 0;
    m_done = 0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
  endtask

  // Apply one rising edge worth of behaviour to the model using the current inputs.
  task automatic model_edge();
    int  sel;
    bit  je, jne, zf, taken;
    sel = int'(bus.PCRegSelect);
    je  = bus.JumpEqual;
    jne = bus.JumpNotEqual;
    zf  = bus.ZeroFlag;
    case (m_mode)
      M_IDLE: begin
        m_pc = 0;
        if (bus.Start) begin m_mode = M_ARM; m_done = 0; end
      end
      M_ARM: begin
        m_pc = 0;
        m_done = 0;
        if (!bus.Start) m_mode = M_RUN;
      end
      M_RUN: begin
        if (bus.Start) begin
          m_mode = M_ARM; m_pc = 0; m_done = 0;
        end else if (bus.Ack) begin
          m_mode = M_DONE; m_done = 1;
        end else if (je || jne) begin
          taken = (je && zf) || (jne && !zf);
          if (taken && sel != 0) m_pc = m_reg[sel];
          else m_pc = (m_pc + 1) % PC_MOD;
        end else begin
          if (sel != 0)
            m_reg[sel] = bus.OffsetEn ? (m_pc + int'(bus.OffsetData)) % PC_MOD : (m_pc + 1) % PC_MOD;
          m_pc = (m_pc + 1) % PC_MOD;
        end
      end
      default: begin
        if (bus.Start) begin m_mode = M_ARM; m_pc = 0; m_done = 0; end
      end
    endcase
  endtask

  task automatic drive(input bit st, input bit je, input bit jne, input bit oe,
                       input int sel, input bit ack, input bit zf, input int off);
    bus.Start        = st;
    bus.JumpEqual    = je;
    bus.JumpNotEqual = jne;
    bus.OffsetEn     = oe;
    bus.PCRegSelect  = 2'(sel);
    bus.Ack          = ack;
    bus.ZeroFlag     = zf;
    bus.OffsetData   = 8'(off);
  endtask

  // Called at posedge+1; advances model and DUT by one cycle, returns at posedge+1.
  task automatic cyc();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
  endtask

  task automatic start_program();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (m_pc != target && guard < 2000) begin
      nop();
      guard++;
    end
    n_total++;
    if (bus.ProgCtr !== pc_t'(target))
      $display("FAIL run_to_%0d: got %0d want %0d", target, bus.ProgCtr, target);
    else n_pass++;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    n_total++;
    if (bus.ProgCtr !== pc_t'(0)) $display("FAIL reset_pc: got %0d want 0", bus.ProgCtr);
    else n_pass++;
    n_total++;
    if (bus.Done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.Done);
    else n_pass++;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    // Controls are ignored while idle.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 1, 3, 0, 0, 77);
      cyc();
      n_total++;
      if (bus.ProgCtr !== pc_t'(0)) $display("FAIL idle_pc: got %0d want 0", bus.ProgCtr);
      else n_pass++;
    end
  endtask

  task automatic test_sequential();
    start_program();
    n_total++;
    if (bus.ProgCtr !== pc_t'(0) || bus.Done !== 1'b0)
      $display("FAIL seq_start: got pc=%0d done=%b want pc=0 done=0", bus.ProgCtr, bus.Done);
    else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      nop();
      n_total++;
      if (bus.ProgCtr !== pc_t'(i) || bus.Done !== 1'b0)
        $display("FAIL seq_pc: got pc=%0d done=%b want pc=%0d done=0", bus.ProgCtr, bus.Done, i);
      else n_pass++;
    end
  endtask

  task automatic test_save_jump();
    start_program();
    run_to(3);
    drive(0, 0, 0, 0, 1, 0, 0, 200);
    cyc();
    n_total++;
    if (bus.ProgCtr !== pc_t'(4)) $display("FAIL spc_advance: got %0d want 4", bus.ProgCtr);
    else n_pass++;
    run_to(9);
    drive(0, 1, 0, 0, 1, 0, 1, 0);
    cyc();
    n_total++;
    if (bus.ProgCtr !== pc_t'(4)) $display("FAIL je_taken: got %0d want 4", bus.ProgCtr);
    else n_pass++;
    drive(0, 1, 0, 0, 1, 0, 0, 0);
    cyc();
    n_total++;
    if (bus.ProgCtr !== pc_t'(5)) $display("FAIL je_not_taken: got %0d want 5", bus.ProgCtr);
    else n_pass++;
    drive(0, 1, 1, 0, 1, 0, 0, 0);
    cyc();
    n_total++;
    if (bus.ProgCtr !== pc_t'(4)) $display("FAIL both_strobes: got %0d want 4", bus.ProgCtr);
    else n_pass++;
  endtask

  task automatic test_offset_jne();
    start_program();
    run_to(6);
    drive(0, 0, 0, 1, 2, 0, 0, 20);
    cyc();
    n_total++;
    if (bus.ProgCtr !== pc_t'(7)) $display("FAIL spc_off_advance: got %0d want 7", bus.ProgCtr);
    else n_pass++;
    drive(0, 0, 1, 0, 2, 0, 1, 0);
    cyc();
    n_total++;
    if (bus.ProgCtr !== pc_t'(8)) $display("FAIL jne_not_taken: got %0d want 8", bus.ProgCtr);
    else n_pass++;
    drive(0, 0, 1, 0, 2, 0, 0, 0);
    cyc();
    n_total++;
    if (bus.ProgCtr !== pc_t'(26)) $display("FAIL jne_taken: got %0d want 26", bus.ProgCtr);
    else n_pass++;
    drive(0, 1, 0, 0, 0, 0, 1, 0);
    cyc();
    n_total++;
    if (bus.ProgCtr !== pc_t'(27)) $display("FAIL taken_sel0: got %0d want 27", bus.ProgCtr);
    else n_pass++;
  endtask

  task automatic test_ack_done();
    start_program();
    run_to(12);
    drive(0, 1, 0, 0, 1, 1, 1, 0);
    cyc();
    n_total++;
    if (bus.ProgCtr !== pc_t'(12) || bus.Done !== 1'b1)
      $display("FAIL ack: got pc=%0d done=%b want pc=12 done=1", bus.ProgCtr, bus.Done);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 1, 2, 0, 0, 9);
      cyc();
      n_total++;
      if (bus.ProgCtr !== pc_t'(12) || bus.Done !== 1'b1)
        $display("FAIL done_hold: got pc=%0d done=%b want pc=12 done=1", bus.ProgCtr, bus.Done);
      else n_pass++;
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    n_total++;
    if (bus.ProgCtr !== pc_t'(0) || bus.Done !== 1'b0)
      $display("FAIL restart: got pc=%0d done=%b want pc=0 done=0", bus.ProgCtr, bus.Done);
    else n_pass++;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    nop();
    n_total++;
    if (bus.ProgCtr !== pc_t'(1)) $display("FAIL rerun: got %0d want 1", bus.ProgCtr);
    else n_pass++;
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    cyc();
    n_total++;
    if (bus.ProgCtr !== pc_t'(0) || bus.Done !== 1'b0)
      $display("FAIL start_beats_ack: got pc=%0d done=%b want pc=0 done=0", bus.ProgCtr, bus.Done);
    else n_pass++;
  endtask

  task automatic test_wrap();
    start_program();
    run_to(1020);
    drive(0, 0, 0, 1, 3, 0, 0, 5);
    cyc();
    run_to(1023);
    nop();
    n_total++;
    if (bus.ProgCtr !== pc_t'(0)) $display("FAIL wrap_pc: got %0d want 0", bus.ProgCtr);
    else n_pass++;
    drive(0, 1, 0, 0, 3, 0, 1, 0);
    cyc();
    n_total++;
    if (bus.ProgCtr !== pc_t'(1)) $display("FAIL wrap_offset: got %0d want 1", bus.ProgCtr);
    else n_pass++;
    // One-instruction loop: save PC+1, then jump to itself twice.
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    cyc();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 1, 0, 1, 0);
      cyc();
      n_total++;
      if (bus.ProgCtr !== pc_t'(2)) $display("FAIL self_loop: got %0d want 2", bus.ProgCtr);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midrun();
    start_program();
    run_to(7);
    @(negedge Clk);
    Reset = 1'b1;
    model_reset();
    #1;
    n_total++;
    if (bus.ProgCtr !== pc_t'(0) || bus.Done !== 1'b0)
      $display("FAIL async_reset: got pc=%0d done=%b want pc=0 done=0", bus.ProgCtr, bus.Done);
    else n_pass++;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    cyc();
    n_total++;
    if (bus.ProgCtr !== pc_t'(0)) $display("FAIL post_reset_idle: got %0d want 0", bus.ProgCtr);
    else n_pass++;
    start_program();
    nop();
    nop();
    for (int s = 1; s <= 3; s++) begin
      drive(0, 0, 1, 0, s, 0, 0, 0);
      cyc();
      n_total++;
      if (bus.ProgCtr !== pc_t'(0))
        $display("FAIL pcreg%0d_cleared: got %0d want 0", s, bus.ProgCtr);
      else n_pass++;
      nop();
    end
  endtask

  task automatic test_random();
    bit st, ack, je, jne;
    start_program();
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom % 40) == 0;
      ack = ($urandom % 50) == 0;
      je  = ($urandom % 4) == 0;
      jne = ($urandom % 4) == 0;
      drive(st, je, jne, 1'($urandom), int'($urandom % 4), ack, 1'($urandom),
            int'($urandom % 256));
      cyc();
      n_total++;
      if (bus.ProgCtr !== pc_t'(m_pc) || bus.Done !== m_done)
        $display("FAIL random_%0d: got pc=%0d done=%b want pc=%0d done=%b",
                 i, bus.ProgCtr, bus.Done, m_pc, m_done);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_save_jump();
    test_offset_jne();
    test_ack_done();
    test_wrap();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
